nem_ohmux_seq_invd: RTL and testbench

//  Parametrised, sequenced successor of the NEM-relay one-hot inverting mux.

---
 rtl/nem_ohmux_seq_invd.sv | 164 ++++++++++++++++
 tb/tb_nem_ohmux_seq_invd.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nem_ohmux_seq_invd.sv
// nem_ohmux_seq_invd
//   Sequenced one-hot inverting mux for NEM-relay crossbar columns.
//   zn = ~din[sel], where the relay select sel_oh is generated internally
//   with break-before-make sequencing. All relays are open for T_BREAK
//   cycles, then the new relay closes and settles for T_MAKE cycles.
//
//   Build option NEM_OHMUX_HOLD_EN: while a switch is in progress, zn keeps
//   the last value captured while zn_valid was high. Without it, zn follows
//   sel_oh live: all ones while every relay is open, and the new input
//   during the settle phase.
//
// Ports
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   req_valid   select-change request
//   req_sel     requested input index (SW bits)
//   req_ready   high only while idle
//   din         N_IN inputs, input i at din[i*WIDTH +: WIDTH]
//   sel_oh      registered one-hot (or all-zero) relay select
//   zn          registered ~(OR_i sel_oh[i] & din_i)
//   zn_valid    zn reflects a settled select
//   err         one-cycle pulse on an out-of-range request

// One output lane: the inverting wired-OR of the lane bits of every input,
// each gated by its relay select.
module nem_ohmux_seq_invd_lane #(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] sel_oh,
    input  logic [N_IN-1:0] bits,
    output logic            zn_d
);
    assign zn_d = ~|(sel_oh & bits);
endmodule

module nem_ohmux_seq_invd #(
    parameter int N_IN    = 2,
    parameter int WIDTH   = 1,
    parameter int T_BREAK = 2,
    parameter int T_MAKE  = 3,
    localparam int SW     = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [SW-1:0]         req_sel,
    output logic                  req_ready,
    input  logic [N_IN*WIDTH-1:0] din,
    output logic [N_IN-1:0]       sel_oh,
    output logic [WIDTH-1:0]      zn,
    output logic                  zn_valid,
    output logic                  err
);
    localparam int TMAX = (T_BREAK > T_MAKE) ? T_BREAK : T_MAKE;
    localparam int CW   = $clog2(TMAX) + 1;

    typedef enum logic [1:0] {IDLE, BRK, MAKE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [SW-1:0]    new_sel, new_sel_nxt;
    logic [SW-1:0]    cur_sel, cur_sel_nxt;
    logic             active, active_nxt;
    logic [N_IN-1:0]  sel_oh_nxt;
    logic             zn_valid_nxt;
    logic             err_nxt;
    logic [WIDTH-1:0] zn_live;

    // Regroup din per lane so each lane sees bit l of every input.
    logic [WIDTH-1:0][N_IN-1:0] lane_bits;

    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        for (genvar i = 0; i < N_IN; i++) begin : g_in
            assign lane_bits[l][i] = din[i*WIDTH + l];
        end
        nem_ohmux_seq_invd_lane #(.N_IN(N_IN)) u_lane (
            .sel_oh (sel_oh),
            .bits   (lane_bits[l]),
            .zn_d   (zn_live[l])
        );
    end

    assign req_ready = (state == IDLE);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        new_sel_nxt  = new_sel;
        cur_sel_nxt  = cur_sel;
        active_nxt   = active;
        sel_oh_nxt   = sel_oh;
        zn_valid_nxt = zn_valid;
        err_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (int'(req_sel) >= N_IN) begin
                        err_nxt = 1'b1;
                    end else if (!(active && req_sel == cur_sel)) begin
                        new_sel_nxt  = req_sel;
                        sel_oh_nxt   = '0;
                        zn_valid_nxt = 1'b0;
                        state_nxt    = BRK;
                        cnt_nxt      = CW'(T_BREAK - 1);
                    end
                end
            end
            BRK: begin
                if (cnt == '0) begin
                    for (int i = 0; i < N_IN; i++)
                        sel_oh_nxt[i] = (int'(new_sel) == i);
                    state_nxt = MAKE;
                    cnt_nxt   = CW'(T_MAKE - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            MAKE: begin
                if (cnt == '0) begin
                    state_nxt    = IDLE;
                    cur_sel_nxt  = new_sel;
                    active_nxt   = 1'b1;
                    zn_valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                sel_oh_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            new_sel  <= '0;
            cur_sel  <= '0;
            active   <= 1'b0;
            sel_oh   <= '0;
            zn_valid <= 1'b0;
            err      <= 1'b0;
            zn       <= '1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            new_sel  <= new_sel_nxt;
            cur_sel  <= cur_sel_nxt;
            active   <= active_nxt;
            sel_oh   <= sel_oh_nxt;
            zn_valid <= zn_valid_nxt;
            err      <= err_nxt;
`ifdef NEM_OHMUX_HOLD_EN
            // Capture on every edge that leaves zn_valid high, including the
            // settle-complete edge, so zn and zn_valid rise together.
            if (zn_valid_nxt)
                zn <= zn_live;
`else
            zn <= zn_live;
`endif
        end
    end
endmodule

// File: tb/tb_nem_ohmux_seq_invd.sv
module tb_nem_ohmux_seq_invd;
    logic       clk = 1'b0;
    logic       rst;
    // 4-input, 2-lane instance
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [7:0] din;
    logic [3:0] sel_oh;
    logic [1:0] zn;
    logic       zn_valid;
    logic       err;
    // 3-input, 1-lane instance
    logic       req_valid3;
    logic [1:0] req_sel3;
    logic       req_ready3;
    logic [2:0] din3;
    logic [2:0] sel_oh3;
    logic [0:0] zn3;
    logic       zn_valid3;
    logic       err3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nem_ohmux_seq_invd #(.N_IN(4), .WIDTH(2), .T_BREAK(2), .T_MAKE(3)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .din(din), .sel_oh(sel_oh), .zn(zn),
        .zn_valid(zn_valid), .err(err)
    );

    nem_ohmux_seq_invd #(.N_IN(3), .WIDTH(1), .T_BREAK(2), .T_MAKE(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_sel(req_sel3),
        .req_ready(req_ready3), .din(din3), .sel_oh(sel_oh3), .zn(zn3),
        .zn_valid(zn_valid3), .err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per cycle after the accept edge (k=0) of a 2-cycle-break,
    // 3-cycle-make switch. zn_valid rises T_BREAK+T_MAKE edges after the
    // accept edge, i.e. in the sixth cycle counting the accept cycle.
    logic [3:0] exp_oh2 [6] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    logic [3:0] exp_oh0 [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    logic       exp_zv  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef NEM_OHMUX_HOLD_EN
    logic [1:0] exp_zn2 [6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
    logic [1:0] exp_zn0 [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
`else
    logic [1:0] exp_zn2 [6] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [1:0] exp_zn0 [6] = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
`endif

    initial begin
        logic [3:0] prev;
        int         wait_n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_sel    = 2'd0;
        req_valid3 = 1'b0;
        req_sel3   = 2'd0;
        // din0=11 din1=00 din2=01 din3=10
        din        = {2'b10, 2'b01, 2'b00, 2'b11};
        din3       = 3'b010;
        #2;
        chk("rst_sel_oh",   {28'd0, sel_oh}, 32'h0);
        chk("rst_zn",       {30'd0, zn}, 32'h3);
        chk("rst_zn_valid", {31'd0, zn_valid}, 32'h0);
        chk("rst_ready",    {31'd0, req_ready}, 32'h1);
        chk("rst_err",      {31'd0, err}, 32'h0);
        #10 rst = 1'b0;
        tick();

        // First select of input 2 from reset
        req_valid = 1'b1;
        req_sel   = 2'd2;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            chk($sformatf("sel2_oh_k%0d", k), {28'd0, sel_oh}, {28'd0, exp_oh2[k]});
            chk($sformatf("sel2_zv_k%0d", k), {31'd0, zn_valid}, {31'd0, exp_zv[k]});
            chk($sformatf("sel2_zn_k%0d", k), {30'd0, zn}, {30'd0, exp_zn2[k]});
        end
        chk("sel2_ready", {31'd0, req_ready}, 32'h1);

        // Same select while active: no break, stays settled
        req_valid = 1'b1;
        req_sel   = 2'd2;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("same_oh_%0d", k), {28'd0, sel_oh}, 32'h4);
            chk($sformatf("same_zv_%0d", k), {31'd0, zn_valid}, 32'h1);
            chk($sformatf("same_rdy_%0d", k), {31'd0, req_ready}, 32'h1);
        end
        req_valid = 1'b0;

        // Switch 2 -> 0; a request during the break must be ignored
        req_valid = 1'b1;
        req_sel   = 2'd0;
        tick();
        req_valid = 1'b0;
        prev = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            if (k == 1) begin
                req_valid = 1'b1;
                req_sel   = 2'd1;
                chk("busy_ready", {31'd0, req_ready}, 32'h0);
            end
            if (k == 2) req_valid = 1'b0;
            chk($sformatf("sw_oh_k%0d", k), {28'd0, sel_oh}, {28'd0, exp_oh0[k]});
            chk($sformatf("sw_zv_k%0d", k), {31'd0, zn_valid}, {31'd0, exp_zv[k]});
            chk($sformatf("sw_zn_k%0d", k), {30'd0, zn}, {30'd0, exp_zn0[k]});
            chk($sformatf("sw_bbm_k%0d", k),
                {31'd0, ($countones(sel_oh) > 1) ||
                        (prev != 4'd0 && sel_oh != 4'd0 && prev != sel_oh)}, 32'h0);
            prev = sel_oh;
        end

        // Async reset in the middle of a break
        req_valid = 1'b1;
        req_sel   = 2'd3;
        tick();
        req_valid = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_oh",    {28'd0, sel_oh}, 32'h0);
        chk("mid_rst_zn",    {30'd0, zn}, 32'h3);
        chk("mid_rst_zv",    {31'd0, zn_valid}, 32'h0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'h1);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("post_rst_oh", {28'd0, sel_oh}, 32'h0);

        // 3-input instance: settle on input 1, then an out-of-range request
        req_valid3 = 1'b1;
        req_sel3   = 2'd1;
        tick();
        req_valid3 = 1'b0;
        wait_n = 0;
        while (!zn_valid3 && wait_n < 20) begin
            tick();
            wait_n++;
        end
        chk("n3_settle_cycles", wait_n, 32'd5);
        chk("n3_oh", {29'd0, sel_oh3}, 32'h2);
        chk("n3_zn", {31'd0, zn3}, 32'h0);
        req_valid3 = 1'b1;
        req_sel3   = 2'd3;
        tick();
        req_valid3 = 1'b0;
        chk("n3_err_pulse", {31'd0, err3}, 32'h1);
        chk("n3_err_oh",    {29'd0, sel_oh3}, 32'h2);
        chk("n3_err_zn",    {31'd0, zn3}, 32'h0);
        chk("n3_err_ready", {31'd0, req_ready3}, 32'h1);
        tick();
        chk("n3_err_clear", {31'd0, err3}, 32'h0);
        chk("n3_err_zv",    {31'd0, zn_valid3}, 32'h1);
        chk("n3_err_oh2",   {29'd0, sel_oh3}, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
